xst_txq: RTL and testbench
==========================

XST_TXQ -- requirements
Module: xst_txq

Interface
REQ-001 Parameter DEPTH, default 4, queue depth in entries; SHALL be a power of two, 2..16.
REQ-002 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset_i  input  1  synchronous, active-high reset.
REQ-004 wr_i  input  1  push request; sampled each rising edge.
REQ-005 wdat_i  input  64  word to transmit, LSB first.
REQ-006 wbits_i  input  6  bit count for the word.
REQ-007 full_o  output  1  queue holds DEPTH entries.
REQ-008 empty_o  output  1  queue holds 0 entries.
REQ-009 count_o  output  5  current occupancy, 0..DEPTH.
REQ-010 ovf_o  output  1  sticky: push dropped because the queue was full.
REQ-011 err_o  output  1  one-cycle pulse: push dropped because wbits_i==0.
REQ-012 idle_i  input  1  shifter idle; high means bit count is zero.
REQ-013 txreg_we_o  output  1  shifter load strobe.
REQ-014 dat_o  output  64  word presented to the shifter; registered.
REQ-015 bits_o  output  6  bit count presented to the shifter; registered.
REQ-016 txreg_oe_o  output  1  shifter read enable.
REQ-017 shdat_i  input  64  shifter parallel read data; valid only while txreg_oe_o is high.
REQ-018 rxdat_o  output  64  captured receive word.
REQ-019 rxvalid_o  output  1  rxdat_o holds an unacknowledged word.
REQ-020 rxack_i  input  1  consumer acknowledge; clears rxvalid_o.
REQ-021 rxovf_o  output  1  sticky: capture overwrote an unacknowledged word.

Function
REQ-022 FIFO SHALL use circular read and write pointers; each pointer wraps from DEPTH-1 to 0.
REQ-023 A push SHALL be accepted only when wr_i=1, full_o=0 at the start of the cycle, and wbits_i!=0.
  - A pop in the same cycle SHALL NOT unblock a push while full.
REQ-024 A push with full_o=1 SHALL be dropped and SHALL set ovf_o.
REQ-025 A push with wbits_i=0 (and full_o=0) SHALL be dropped and SHALL pulse err_o in the following cycle.
REQ-026 A simultaneous accepted push and pop SHALL leave count_o unchanged.
REQ-027 The state machine SHALL have four states: IDLE, LOAD, BUSY, CAPT.
REQ-028 IDLE -> LOAD when empty_o=0 and idle_i=1.
  - On this edge: head entry -> dat_o/bits_o, read pointer advances, count_o decrements.
REQ-029 LOAD: txreg_we_o=1 for exactly one cycle; next state is always BUSY.
REQ-030 BUSY: ignore idle_i for its first cycle; thereafter -> CAPT when idle_i=1.
REQ-031 CAPT: txreg_oe_o=1 for exactly one cycle; shdat_i -> rxdat_o and rxvalid_o set on that edge; next state IDLE.
REQ-032 If rxvalid_o=1 at a CAPT edge, rxdat_o SHALL be overwritten and rxovf_o set.
  - If rxack_i is high on that same edge, the capture SHALL win: rxvalid_o stays 1 and rxovf_o is not set.
REQ-033 rxack_i with no capture on the same edge SHALL clear rxvalid_o on the next edge.
REQ-034 txreg_we_o and txreg_oe_o SHALL be decoded from the state only and SHALL never be high together.
REQ-035 Latency: push accepted at edge k into an empty queue with idle_i=1 -> txreg_we_o high in the cycle following edge k+1.
REQ-036 Back-to-back words SHALL be separated by at least one IDLE cycle (minimum 4 cycles per word) plus the shifter time.
REQ-037 The block SHALL NOT generate baud or shift timing; the shifter owns that timing.

Reset
REQ-038 While reset_i=1, the following SHALL hold on the edge:
  - state=IDLE, both pointers=0, count_o=0, empty_o=1, full_o=0;
  - ovf_o=0, err_o=0, txreg_we_o=0, txreg_oe_o=0;
  - dat_o=0, bits_o=0, rxdat_o=0, rxvalid_o=0, rxovf_o=0.
REQ-039 Reset mid-transfer SHALL abort in any state and discard all queued entries; reset_i SHALL override wr_i and rxack_i.

Configuration
REQ-040 With XST_TXQ_RXCAP_EN defined, the receive-capture path (CAPT state, REQ-031..033) SHALL be present.
REQ-041 Without XST_TXQ_RXCAP_EN:
  - BUSY SHALL go directly to IDLE when idle_i=1;
  - txreg_oe_o, rxdat_o, rxvalid_o and rxovf_o SHALL be tied to 0, and rxack_i and shdat_i SHALL be ignored.

Verification
REQ-042 Reset, then push 64'h0123456789ABCDEF with bits 10, idle_i=1 -> txreg_we_o pulses once with dat_o=64'h0123456789ABCDEF and bits_o=10, two cycles after the push edge.
REQ-043 Push 5 words with DEPTH=4 and idle_i held 0 -> count_o=4, full_o=1, ovf_o=1; fifth word never appears on dat_o.
REQ-044 Push with wbits_i=0 -> err_o pulses for one cycle; count_o stays 0; txreg_we_o stays 0.
REQ-045 (RXCAP_EN) Word loaded, idle_i low 12 cycles then high, shdat_i=64'hA5 -> txreg_oe_o pulses once, rxdat_o=64'hA5, rxvalid_o=1; a second transfer without rxack_i -> rxovf_o=1.
REQ-046 Assert reset_i in BUSY with 3 entries queued -> next cycle count_o=0, state IDLE, no further txreg_we_o until a new push.
REQ-047 Keep the queue full while pushing and popping in the same cycles -> drops only when full at cycle start; pointer wrap preserves FIFO order across 20 words.

Source files
------------

// File: rtl/xst_txq.sv
// rtl/xst_txq.sv - transmit word queue with load/capture handshake to an external shifter
// Optional receive capture path (CAPT state) enabled by defining XST_TXQ_RXCAP_EN.
module xst_txq #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wr_i,
    input  logic [63:0] wdat_i,
    input  logic [5:0]  wbits_i,
    output logic        full_o,
    output logic        empty_o,
    output logic [4:0]  count_o,
    output logic        ovf_o,
    output logic        err_o,
    input  logic        idle_i,
    output logic        txreg_we_o,
    output logic [63:0] dat_o,
    output logic [5:0]  bits_o,
    output logic        txreg_oe_o,
    input  logic [63:0] shdat_i,
    output logic [63:0] rxdat_o,
    output logic        rxvalid_o,
    input  logic        rxack_i,
    output logic        rxovf_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, BUSY, CAPT} state_t;

    state_t         state;
    logic           busy_first;
    logic [63:0]    mem_dat  [DEPTH];
    logic [5:0]     mem_bits [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [4:0]     count;
    logic           push;
    logic           pop;

    assign full_o     = (count == DEPTH_C);
    assign empty_o    = (count == 5'd0);
    assign count_o    = count;
    // full_o is the start-of-cycle occupancy, so a same-cycle pop never admits a push
    assign push       = wr_i && !full_o && (wbits_i != 6'd0);
    assign pop        = (state == IDLE) && !empty_o && idle_i;
    assign txreg_we_o = (state == LOAD);

    always_ff @(posedge clk_i) begin
        if (push && !reset_i) begin
            mem_dat[wptr]  <= wdat_i;
            mem_bits[wptr] <= wbits_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= IDLE;
            busy_first <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            count      <= 5'd0;
            ovf_o      <= 1'b0;
            err_o      <= 1'b0;
            dat_o      <= 64'd0;
            bits_o     <= 6'd0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            if (wr_i && full_o) ovf_o <= 1'b1;
            err_o <= wr_i && !full_o && (wbits_i == 6'd0);

            case (state)
                IDLE: begin
                    if (pop) begin
                        dat_o  <= mem_dat[rptr];
                        bits_o <= mem_bits[rptr];
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    busy_first <= 1'b1;
                    state      <= BUSY;
                end
                BUSY: begin
                    // the shifter may still report idle in the cycle right after the load
                    busy_first <= 1'b0;
                    if (!busy_first && idle_i) begin
`ifdef XST_TXQ_RXCAP_EN
                        state <= CAPT;
`else
                        state <= IDLE;
`endif
                    end
                end
                CAPT:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef XST_TXQ_RXCAP_EN
    assign txreg_oe_o = (state == CAPT);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rxdat_o   <= 64'd0;
            rxvalid_o <= 1'b0;
            rxovf_o   <= 1'b0;
        end else if (state == CAPT) begin
            // a capture beats a same-edge acknowledge
            rxdat_o   <= shdat_i;
            rxvalid_o <= 1'b1;
            if (rxvalid_o && !rxack_i) rxovf_o <= 1'b1;
        end else if (rxack_i) begin
            rxvalid_o <= 1'b0;
        end
    end
`else
    logic unused_rx;

    assign txreg_oe_o = 1'b0;
    assign rxdat_o    = 64'd0;
    assign rxvalid_o  = 1'b0;
    assign rxovf_o    = 1'b0;
    assign unused_rx  = ^{rxack_i, shdat_i};
`endif

endmodule

// File: tb/tb_xst_txq.sv
// tb/tb_xst_txq.sv - randomized bench for xst_txq against a queue-based behavioural model
// Capture-path expectations follow XST_TXQ_RXCAP_EN when it is defined for the build.
module tb_xst_txq;
    localparam int DEPTH = 4;
`ifdef XST_TXQ_RXCAP_EN
    localparam bit RXCAP = 1'b1;
`else
    localparam bit RXCAP = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i, wr_i, idle_i, rxack_i;
    logic [63:0] wdat_i, shdat_i;
    logic [5:0]  wbits_i;
    logic        full_o, empty_o, ovf_o, err_o, txreg_we_o, txreg_oe_o, rxvalid_o, rxovf_o;
    logic [4:0]  count_o;
    logic [63:0] dat_o, rxdat_o;
    logic [5:0]  bits_o;

    xst_txq #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .wr_i(wr_i), .wdat_i(wdat_i), .wbits_i(wbits_i),
        .full_o(full_o), .empty_o(empty_o), .count_o(count_o), .ovf_o(ovf_o), .err_o(err_o),
        .idle_i(idle_i), .txreg_we_o(txreg_we_o), .dat_o(dat_o), .bits_o(bits_o),
        .txreg_oe_o(txreg_oe_o), .shdat_i(shdat_i), .rxdat_o(rxdat_o), .rxvalid_o(rxvalid_o),
        .rxack_i(rxack_i), .rxovf_o(rxovf_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // model: pending words, transfer age in cycles since the pop edge (0 = none), capture cycle flag
    logic [69:0] m_q[$];
    int          m_age;
    bit          m_capt;
    logic [63:0] m_dat, m_rxdat;
    logic [5:0]  m_bits;
    bit          m_ovf, m_err, m_rxvalid, m_rxovf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_age = 0; m_capt = 0;
        m_dat = '0; m_bits = '0; m_rxdat = '0;
        m_ovf = 0; m_err = 0; m_rxvalid = 0; m_rxovf = 0;
    endtask

    task automatic model_step();
        bit full, do_pop, do_push, cap;
        logic [69:0] w;
        if (reset_i) begin
            model_reset();
            return;
        end
        full    = (m_q.size() == DEPTH);
        do_pop  = (m_age == 0) && !m_capt && (m_q.size() != 0) && idle_i;
        do_push = wr_i && !full && (wbits_i != 0);
        m_err   = wr_i && !full && (wbits_i == 0);
        if (wr_i && full) m_ovf = 1;
        cap = m_capt;
        if (RXCAP) begin
            if (cap) begin
                if (m_rxvalid && !rxack_i) m_rxovf = 1;
                m_rxdat = shdat_i;
                m_rxvalid = 1;
            end else if (rxack_i) begin
                m_rxvalid = 0;
            end
        end
        if (cap) m_capt = 0;
        else if (m_age >= 3 && idle_i) begin
            m_age = 0;
            m_capt = RXCAP;
        end else if (m_age >= 1) m_age++;
        if (do_pop) begin
            w = m_q.pop_front();
            m_bits = w[69:64];
            m_dat = w[63:0];
            m_age = 1;
        end
        if (do_push) m_q.push_back({wbits_i, wdat_i});
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("count", 64'(count_o), 64'(m_q.size()));
            chk("full", 64'(full_o), 64'(m_q.size() == DEPTH));
            chk("empty", 64'(empty_o), 64'(m_q.size() == 0));
            chk("ovf", 64'(ovf_o), 64'(m_ovf));
            chk("err", 64'(err_o), 64'(m_err));
            chk("we", 64'(txreg_we_o), 64'(m_age == 1));
            chk("oe", 64'(txreg_oe_o), 64'(m_capt));
            chk("dat", dat_o, m_dat);
            chk("bits", 64'(bits_o), 64'(m_bits));
            chk("rxdat", rxdat_o, m_rxdat);
            chk("rxvalid", 64'(rxvalid_o), 64'(m_rxvalid));
            chk("rxovf", 64'(rxovf_o), 64'(m_rxovf));
        end
    end

    task automatic cyc(input bit w, input logic [63:0] d, input logic [5:0] b,
                       input bit idl, input bit ack, input bit r);
        wr_i = w; wdat_i = d; wbits_i = b; idle_i = idl; rxack_i = ack; reset_i = r;
        shdat_i = {$urandom, $urandom};
        @(posedge clk_i);
        model_step();
        #2;
    endtask

    initial begin
        model_reset();
        cyc(1, 64'hDEAD, 6'd5, 1, 1, 1);
        cyc(0, 0, 0, 1, 0, 1);
        chk_en = 1'b1;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_dat", dat_o, 64'd0);

        // push-to-load latency
        cyc(1, 64'h0123456789ABCDEF, 6'd10, 1, 0, 0);
        chk("lat_count", 64'(count_o), 64'd1);
        chk("lat_we_early", 64'(txreg_we_o), 64'd0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("lat_we", 64'(txreg_we_o), 64'd1);
        chk("lat_dat", dat_o, 64'h0123456789ABCDEF);
        chk("lat_bits", 64'(bits_o), 64'd10);
        cyc(0, 0, 0, 1, 0, 0);
        chk("lat_we_once", 64'(txreg_we_o), 64'd0);
        repeat (6) cyc(0, 0, 0, 1, 0, 0);

        // zero-length push
        cyc(1, 64'h55, 6'd0, 1, 0, 0);
        chk("zl_err", 64'(err_o), 64'd1);
        chk("zl_count", 64'(count_o), 64'd0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("zl_err_clear", 64'(err_o), 64'd0);
        chk("zl_we", 64'(txreg_we_o), 64'd0);

        // overflow with shifter busy
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 64'(100 + i), 6'(i + 1), 0, 0, 0);
        chk("ovf_count", 64'(count_o), 64'd4);
        chk("ovf_full", 64'(full_o), 64'd1);
        chk("ovf_flag", 64'(ovf_o), 64'd1);

        // reset while busy with three entries queued
        cyc(0, 0, 0, 1, 0, 0);
        chk("mid_dat", dat_o, 64'd100);
        cyc(0, 0, 0, 0, 0, 0);
        chk("mid_count", 64'(count_o), 64'd3);
        cyc(0, 0, 0, 1, 0, 1);
        chk("mid_rst_count", 64'(count_o), 64'd0);
        chk("mid_rst_ovf", 64'(ovf_o), 64'd0);
        repeat (6) cyc(0, 0, 0, 1, 0, 0);

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] b;
            b = ($urandom_range(7) == 0) ? 6'd0 : 6'($urandom_range(63, 1));
            cyc($urandom_range(1), {$urandom, $urandom}, b, $urandom_range(9) < 6,
                $urandom_range(4) == 0, $urandom_range(199) == 0);
        end

        // saturated queue: pushes every cycle while words drain
        cyc(0, 0, 0, 1, 0, 1);
        for (int n = 0; n < 400; n++)
            cyc(1, 64'(n), 6'($urandom_range(63, 1)), $urandom_range(3) != 0, $urandom_range(1), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
